// File: rtl/fir_multichannel_engine.sv
// fir_multichannel_engine
//   Time-multiplexed multi-channel FIR core. One shared MAC serves NChannels
//   independent delay lines with a single active coefficient set. Coefficients
//   arrive serially into a shadow register. They are copied to the active set
//   after lock falls, but only while no computation is using them.
//
// Build option:
//   FIR_SATURATE_EN  defined: output clamps to the signed DataWidth range.
//                    undefined: output wraps (low DataWidth bits kept).
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous active-high, clears all state
//   start        one-cycle sample strobe (x, chan sampled with it)
//   chan         channel of x
//   x            signed input sample
//   lock         high while the coefficient stream is written
//   coeffLoadIn  serial shift enable for the shadow coefficients
//   coeffIn      serial coefficient bit (h[0] first, MSB first)
//   y            signed filter output, held until the next done
//   yChan        channel of y
//   done         one-cycle pulse, y/yChan valid
//   busy         computation in progress (includes the done cycle)
//   drop         one-cycle pulse, the previous cycle's start was rejected
module fir_multichannel_engine #(
  parameter int NTaps      = 8,
  parameter int NChannels  = 2,
  parameter int DataWidth  = 12,
  parameter int CoeffWidth = 12,
  localparam int ChanWidth = (NChannels > 1) ? $clog2(NChannels) : 1,
  localparam int AccWidth  = DataWidth + CoeffWidth + $clog2(NTaps)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ChanWidth-1:0]        chan,
  input  logic signed [DataWidth-1:0] x,
  input  logic                        lock,
  input  logic                        coeffLoadIn,
  input  logic                        coeffIn,
  output logic signed [DataWidth-1:0] y,
  output logic [ChanWidth-1:0]        yChan,
  output logic                        done,
  output logic                        busy,
  output logic                        drop
);

  localparam int KWidth  = $clog2(NTaps);
  localparam int ProdW   = DataWidth + CoeffWidth;
  localparam int ShadowW = NTaps * CoeffWidth;
  localparam logic [ChanWidth:0] NChanL = (ChanWidth + 1)'(NChannels);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                         state, stateNext;
  logic [KWidth-1:0]              k;
  logic [ChanWidth-1:0]           curChan;
  logic signed [AccWidth-1:0]     acc;
  logic signed [DataWidth-1:0]    d [NChannels][NTaps];
  logic signed [CoeffWidth-1:0]   hAct [NTaps];
  logic [ShadowW-1:0]             shadow;
  logic                           lockQ;
  logic                           commitPending;
  logic                           chanOk;
  logic                           accept;
  logic                           commit;
  logic signed [ProdW-1:0]        prod;
  logic signed [AccWidth-1:0]     accShift;

  function automatic logic signed [DataWidth-1:0] shapeOut(
    input logic signed [AccWidth-1:0] v
  );
`ifdef FIR_SATURATE_EN
    logic signed [AccWidth-1:0] maxOut;
    logic signed [AccWidth-1:0] minOut;
    maxOut = AccWidth'(2 ** (DataWidth - 1) - 1);
    minOut = AccWidth'(-(2 ** (DataWidth - 1)));
    if (v > maxOut)      return DataWidth'(maxOut);
    else if (v < minOut) return DataWidth'(minOut);
    else                 return DataWidth'(v);
`else
    return DataWidth'(v);
`endif
  endfunction

  assign chanOk   = {1'b0, chan} < NChanL;
  assign prod     = d[curChan][k] * hAct[k];
  assign accShift = acc >>> (CoeffWidth - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Commit is held off while a start is taken so a computation never sees a
  // coefficient set change between its first and last tap.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        accept = start && !lock && chanOk;
        commit = commitPending && !accept;
        if (accept) stateNext = MAC;
      end
      MAC: begin
        if (k == KWidth'(NTaps - 1)) stateNext = OUT;
      end
      OUT: begin
        commit    = commitPending;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NChannels; c++)
        for (int t = 0; t < NTaps; t++)
          d[c][t] <= '0;
      for (int t = 0; t < NTaps; t++)
        hAct[t] <= '0;
      shadow        <= '0;
      lockQ         <= 1'b0;
      commitPending <= 1'b0;
      acc           <= '0;
      k             <= '0;
      curChan       <= '0;
      y             <= '0;
      yChan         <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      drop          <= 1'b0;
    end else begin
      lockQ <= lock;
      done  <= 1'b0;
      drop  <= start && !accept;

      if (coeffLoadIn) shadow <= {shadow[ShadowW-2:0], coeffIn};

      // A new falling edge wins over a commit on the same edge so the most
      // recent stream is never lost.
      if (lockQ && !lock) commitPending <= 1'b1;
      else if (commit)    commitPending <= 1'b0;

      if (commit)
        for (int t = 0; t < NTaps; t++)
          hAct[t] <= shadow[(NTaps - t) * CoeffWidth - 1 -: CoeffWidth];

      if (accept) busy <= 1'b1;
      else if (state == IDLE) busy <= 1'b0;

      // Accept: push sample into the selected delay line
      if (accept) begin
        for (int t = NTaps - 1; t > 0; t--)
          d[chan][t] <= d[chan][t - 1];
        d[chan][0] <= x;
        curChan    <= chan;
        acc        <= '0;
        k          <= '0;
      end

      // MAC: one tap per cycle
      if (state == MAC) begin
        acc <= acc + AccWidth'(prod);
        k   <= k + 1'b1;
      end

      // OUT: scale, shape and present
      if (state == OUT) begin
        y     <= shapeOut(accShift);
        yChan <= curChan;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_multichannel_engine.sv
module tb_fir_multichannel_engine;

  localparam int NT  = 8;
  localparam int NC  = 3;
  localparam int DW  = 12;
  localparam int CW  = 12;
  localparam int ChW = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [ChW-1:0]       chan;
  logic signed [DW-1:0] x;
  logic                 lock;
  logic                 coeffLoadIn;
  logic                 coeffIn;
  logic signed [DW-1:0] y;
  logic [ChW-1:0]       yChan;
  logic                 done;
  logic                 busy;
  logic                 drop;

  fir_multichannel_engine #(
    .NTaps(NT), .NChannels(NC), .DataWidth(DW), .CoeffWidth(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .chan(chan), .x(x),
    .lock(lock), .coeffLoadIn(coeffLoadIn), .coeffIn(coeffIn),
    .y(y), .yChan(yChan), .done(done), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int edgeCnt = 0;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  typedef struct {
    int y;
    int ch;
    int at;
  } res_t;

  res_t expQ[$];
  int   dropQ[$];
  res_t monR;
  int   checks = 0;
  int   fails = 0;
  int   lastY = 0;
  int   lastCh = 0;

  // Behavioural model state
  int   dl [NC][NT];
  int   hAct [NT];
  int   hShadow [NT];
  int   lastAccept;
  bit   pending;
  int   fallEdge;
  bit   lockModel;

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic int expectY(input int c);
    longint s;
    longint sh;
    logic [DW-1:0] lo;
    s = 0;
    for (int t = 0; t < NT; t++) s += longint'(dl[c][t]) * longint'(hAct[t]);
    sh = s >>> (CW - 1);
`ifdef FIR_SATURATE_EN
    if (sh > 2047) return 2047;
    if (sh < -2048) return -2048;
    return int'(sh);
`else
    lo = sh[DW-1:0];
    return int'(signed'(lo));
`endif
  endfunction

  task automatic modelReset();
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < NT; t++) dl[c][t] = 0;
    for (int t = 0; t < NT; t++) begin
      hAct[t] = 0;
      hShadow[t] = 0;
    end
    lastAccept = -1000;
    pending = 0;
    fallEdge = -1000;
    lockModel = 0;
    expQ.delete();
    dropQ.delete();
    lastY = 0;
    lastCh = 0;
  endtask

  // Called just after a falling clock edge; consumes one cycle.
  task automatic issue(input int c, input int xv, input bit lk);
    int  e0;
    bit  acc;
    res_t r;
    e0 = edgeCnt + 1;
    start = 1'b1;
    chan  = ChW'(c);
    x     = DW'(xv);
    lock  = lk;
    acc = (e0 >= lastAccept + NT + 2) && !lk && (c < NC);
    if (acc && pending && e0 >= fallEdge + 2) begin
      hAct = hShadow;
      pending = 0;
    end
    if (lockModel && !lk) begin
      pending = 1;
      fallEdge = e0;
    end
    lockModel = lk;
    if (acc) begin
      for (int t = NT - 1; t > 0; t--) dl[c][t] = dl[c][t-1];
      dl[c][0] = xv;
      r.y  = expectY(c);
      r.ch = c;
      r.at = e0 + NT + 1;
      expQ.push_back(r);
      lastAccept = e0;
    end else begin
      dropQ.push_back(e0);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 64 && (edgeCnt + 1 < lastAccept + NT + 2); i++) @(negedge clk);
  endtask

  task automatic waitUntilEdge(input int e);
    for (int i = 0; i < 64 && (edgeCnt + 1 < e); i++) @(negedge clk);
  endtask

  task automatic releaseLock();
    if (lockModel) begin
      lock = 1'b0;
      fallEdge = edgeCnt + 1;
      pending = 1;
      lockModel = 0;
      repeat (3) @(negedge clk);
    end
  endtask

  // Leaves lock high; caller drops it with releaseLock or together with a start.
  task automatic loadCoeffs(input int h [NT]);
    logic [CW-1:0] bits;
    waitIdle();
    for (int i = 0; i < 8 && (edgeCnt < fallEdge + 1); i++) @(negedge clk);
    if (pending) begin
      hAct = hShadow;
      pending = 0;
    end
    lock = 1'b1;
    lockModel = 1;
    for (int i = 0; i < NT; i++) begin
      bits = CW'(h[i]);
      for (int b = CW - 1; b >= 0; b--) begin
        coeffLoadIn = 1'b1;
        coeffIn = bits[b];
        @(negedge clk);
      end
    end
    coeffLoadIn = 1'b0;
    coeffIn = 1'b0;
    hShadow = h;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (expQ.size() > 0 && edgeCnt > expQ[0].at) begin
        chk("done_missing", int'(done), 1);
        void'(expQ.pop_front());
      end
      if (done) begin
        if (expQ.size() == 0) chk("done_unexpected", int'(done), 0);
        else begin
          monR = expQ.pop_front();
          chk("y", int'(y), monR.y);
          chk("yChan", int'(yChan), monR.ch);
          chk("done_edge", edgeCnt, monR.at);
          lastY = monR.y;
          lastCh = monR.ch;
        end
      end
      if (dropQ.size() > 0 && edgeCnt > dropQ[0]) begin
        chk("drop_missing", int'(drop), 1);
        void'(dropQ.pop_front());
      end
      if (drop) begin
        if (dropQ.size() == 0) chk("drop_unexpected", int'(drop), 0);
        else chk("drop_edge", edgeCnt, dropQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hv [NT];
    int e0;
    int r;
    reset = 1'b1;
    start = 1'b0;
    chan = '0;
    x = '0;
    lock = 1'b0;
    coeffLoadIn = 1'b0;
    coeffIn = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    chk("rst_y", int'(y), 0);
    chk("rst_yChan", int'(yChan), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drop", int'(drop), 0);
    reset = 1'b0;
    @(negedge clk);

    // Zero coefficients: first result is 0, nothing before done
    issue(0, 100, 0);
    chk("busy_after_start", int'(busy), 1);
    for (int i = 0; i < NT + 1; i++) begin
      chk("quiet_pre_done", int'({done, drop, yChan, y}), 0);
      if (i < NT) @(negedge clk);
    end
    waitIdle();

    // Single tap of 0.5
    for (int t = 0; t < NT; t++) hv[t] = 0;
    hv[0] = 'h400;
    loadCoeffs(hv);
    releaseLock();
    issue(1, 1000, 0);
    waitIdle();

    // All taps 0.25, interleaved channels
    for (int t = 0; t < NT; t++) hv[t] = 'h200;
    loadCoeffs(hv);
    releaseLock();
    for (int i = 0; i < NT; i++) begin
      waitIdle();
      issue(0, 400, 0);
      waitIdle();
      issue(1, -400, 0);
    end
    waitIdle();
    repeat (2) @(negedge clk);
    chk("y_final_ch1", int'(y), -800);

    // Busy rejection, done-cycle rejection, then minimum spacing accepted
    issue(0, 5, 0);
    e0 = lastAccept;
    repeat (2) @(negedge clk);
    issue(1, 7, 0);
    waitUntilEdge(e0 + NT + 1);
    issue(2, 9, 0);
    issue(2, 13, 0);
    waitIdle();
    repeat (3) @(negedge clk);
    chk("y_hold", int'(y), lastY);
    chk("yChan_hold", int'(yChan), lastCh);

    // Lock rising with start, then out-of-range channel
    issue(0, 9, 1);
    releaseLock();
    issue(3, 11, 0);
    repeat (NT + 3) @(negedge clk);

    // Lock falls with start: old coefficients, then new ones
    for (int t = 0; t < NT; t++) hv[t] = 64 * (t + 1);
    loadCoeffs(hv);
    issue(0, 123, 0);
    waitIdle();
    issue(0, -77, 0);
    waitIdle();

    // Full-scale input and coefficients
    for (int t = 0; t < NT; t++) hv[t] = 'h7FF;
    loadCoeffs(hv);
    releaseLock();
    for (int i = 0; i < NT; i++) begin
      waitIdle();
      issue(2, 2047, 0);
    end
    waitIdle();
    repeat (2) @(negedge clk);
`ifdef FIR_SATURATE_EN
    chk("fullscale_y", int'(y), 2047);
`else
    chk("fullscale_y", int'(y), -16);
`endif

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        for (int t = 0; t < NT; t++) hv[t] = int'($urandom_range(0, 4095)) - 2048;
        loadCoeffs(hv);
        releaseLock();
      end else if (r == 1) begin
        issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)) - 2048, 1);
        releaseLock();
      end else begin
        repeat ($urandom_range(0, 12)) @(negedge clk);
        issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)) - 2048, 0);
      end
    end
    waitIdle();
    repeat (3) @(negedge clk);

    // Reset in the middle of a computation
    issue(2, 300, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    lock = 1'b0;
    modelReset();
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_y", int'(y), 0);
    reset = 1'b0;
    repeat (NT + 6) @(negedge clk);
    for (int t = 0; t < NT; t++) hv[t] = 'h400;
    loadCoeffs(hv);
    releaseLock();
    issue(2, 300, 0);

    for (int i = 0; i < 40 && (expQ.size() + dropQ.size() > 0); i++) @(negedge clk);
    chk("queues_drained", expQ.size() + dropQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
